// File: rtl/int_divider.sv
// int_divider: multi-cycle restoring integer divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes, and the signs are applied in a final
// fix-up cycle. Quotient goes to lo and remainder goes to hi. Divide-by-zero
// returns lo = all ones and hi = the raw dividend.
module int_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         int_exe,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         intdiv_ready,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         div_zero
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   rem;       // partial remainder
    logic [W-1:0]   quo;       // dividend magnitude shifting out, quotient shifting in
    logic [W-1:0]   dvsr;      // divisor magnitude
    logic [W-1:0]   dvd_raw;   // original dividend bits, returned in hi on divide-by-zero
    logic           neg_q;     // quotient needs negation (operand signs differ)
    logic           neg_r;     // remainder needs negation (dividend negative)
    logic           dz;        // divisor was zero

    logic           start;
    logic [W-1:0]   dvd_mag, dvs_mag;
    logic [W:0]     shifted, trial;

    assign start = (state == IDLE) && int_exe;

    // Operand magnitudes and the restoring trial subtraction (W+1 bits wide so the
    // borrow acts as the sign). Negating MIN gives 2^(W-1) as an unsigned value.
    always_comb begin
        dvd_mag = (signed_op && dividend[W-1]) ? (~dividend + 1'b1) : dividend;
        dvs_mag = (signed_op && divisor[W-1])  ? (~divisor + 1'b1)  : divisor;
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, dvsr};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: W CALC cycles, then a single FIX cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (int_exe) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift/subtract iterations, and sign fix-up into lo/hi
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            dvd_raw      <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            dz           <= 1'b0;
            intdiv_ready <= 1'b0;
            lo           <= '0;
            hi           <= '0;
            div_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_raw      <= dividend;
                        neg_q        <= signed_op & (dividend[W-1] ^ divisor[W-1]);
                        neg_r        <= signed_op & dividend[W-1];
                        dz           <= (divisor == '0);
                        quo          <= dvd_mag;
                        dvsr         <= dvs_mag;
                        rem          <= '0;
                        cnt          <= CW'(W - 1);
                        intdiv_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (!trial[W]) begin
                        rem <= trial[W-1:0];
                        quo <= {quo[W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[W-1:0];
                        quo <= {quo[W-2:0], 1'b0};
                    end
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    intdiv_ready <= 1'b0;
                    if (dz) begin
                        lo       <= '1;
                        hi       <= dvd_raw;
                        div_zero <= 1'b1;
                    end else begin
                        lo       <= neg_q ? (~quo + 1'b1) : quo;
                        hi       <= neg_r ? (~rem + 1'b1) : rem;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_divider.sv
// tb_int_divider: table-driven checks of int_divider (W=32) plus directed sequences
// covering a start pulse issued mid-divide and a reset issued mid-divide.
module tb_int_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         int_exe;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         intdiv_ready;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         div_zero;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_divider #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .int_exe      (int_exe),
        .signed_op    (signed_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .intdiv_ready (intdiv_ready),
        .lo           (lo),
        .hi           (hi),
        .div_zero     (div_zero)
    );

    typedef struct {
        string        name;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        logic         exp_dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start a divide at the current negedge. After the start edge, scramble the
    // inputs, then count consecutive busy cycles. Returns at the negedge of the
    // first idle cycle.
    task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int busy);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        int_exe   = 1'b1;
        @(posedge clk);
        #1;
        int_exe   = 1'b0;
        signed_op = ~s;
        dividend  = $urandom;
        divisor   = $urandom;
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (intdiv_ready) busy++;
            else break;
        end
    endtask

    initial begin
        int busy;
        logic [W-1:0] prev_lo, prev_hi;

        vecs[0]  = '{"u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{"s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[3]  = '{"u5/0",        1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        vecs[4]  = '{"u9/3",        1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
        vecs[5]  = '{"sMIN/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[6]  = '{"uMIN/FFFF",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[7]  = '{"s-7/-2",      1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{"s-5/0",       1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
        vecs[9]  = '{"uMAX/1",      1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[10] = '{"uMAX/16",     1'b0, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 32'd15,       1'b0};
        vecs[11] = '{"sMIN/2",      1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};

        reset = 1'b1; int_exe = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, intdiv_ready}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);

        // Table vectors, issued back to back in the first idle cycle after each result
        for (int i = 0; i < 12; i++) begin
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, busy);
            check({vecs[i].name, " busy"}, busy, W + 1);
            check({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
            check({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, " dz"}, {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
        end
        prev_lo = vecs[11].exp_lo;
        prev_hi = vecs[11].exp_hi;

        // Outputs hold while idle, even when inputs change
        dividend = 32'd77; divisor = 32'd0; signed_op = 1'b1;
        repeat (3) @(negedge clk);
        check("hold lo", lo, prev_lo);
        check("hold hi", hi, prev_hi);

        // A second start pulse mid-divide is ignored; the busy window is unchanged
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; int_exe = 1'b1;
        @(posedge clk);
        #1 int_exe = 1'b0;
        busy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) begin
                int_exe = 1'b1; signed_op = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else if (k == 11) begin
                int_exe = 1'b0; dividend = 32'd1; divisor = 32'd1;
            end
            if (k == 20) begin
                check("calc lo held", lo, prev_lo);
                check("calc hi held", hi, prev_hi);
            end
            if (intdiv_ready) busy++;
            else break;
        end
        check("ignore busy", busy, W + 1);
        check("ignore lo", lo, 32'd14);
        check("ignore hi", hi, 32'd2);
        check("ignore dz", {31'd0, div_zero}, 32'd0);

        // Reset mid-divide aborts the divide and clears the outputs
        signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3; int_exe = 1'b1;
        @(posedge clk);
        #1 int_exe = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("pre-rst busy", {31'd0, intdiv_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort ready", {31'd0, intdiv_ready}, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort hi", hi, 32'd0);
        @(negedge clk);
        check("abort stays idle", {31'd0, intdiv_ready}, 32'd0);

        // When reset and int_exe are asserted together, reset wins
        reset = 1'b1; int_exe = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        reset = 1'b0; int_exe = 1'b0;
        @(negedge clk);
        check("rst+exe ready", {31'd0, intdiv_ready}, 32'd0);
        check("rst+exe lo", lo, 32'd0);

        // Normal divide after the abort
        do_div(1'b0, 32'd20, 32'd4, busy);
        check("post-rst busy", busy, W + 1);
        check("post-rst lo", lo, 32'd5);
        check("post-rst hi", hi, 32'd0);
        check("post-rst dz", {31'd0, div_zero}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_divider.md
# int_divider

Multi-cycle integer divide unit that responds to the instruction sequencer's `int_exe` start pulse. It performs a W-bit restoring (one quotient bit per cycle) division, signed or unsigned. It reports busy on `intdiv_ready` and presents quotient on `lo` and remainder on `hi` for later write-back and `mvlo`/`mvhi` moves. It sits beside the ALU in the datapath; the sequencer holds its wait state while `intdiv_ready` is high.

## Interface

Parameters:
- `W`, default 32: operand/result width (≥ 2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `int_exe`  in  1  start pulse from sequencer; sampled only in IDLE.
- `signed_op`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with `int_exe`.
- `dividend`  in  W  numerator; sampled with `int_exe`.
- `divisor`  in  W  denominator; sampled with `int_exe`.
- `intdiv_ready`  out  1  registered busy flag: 1 while a divide is in flight (name fixed by sequencer port).
- `lo`  out  W  quotient, registered.
- `hi`  out  W  remainder, registered.
- `div_zero`  out  1  1 if the last completed divide had divisor == 0; registered.

## Operation

- States: IDLE, CALC, FIX.
- IDLE, `int_exe`=1:
  - Latch `signed_op`, dividend sign, divisor sign, and divisor==0.
  - Load magnitude registers. Signed: two's-complement absolute value, where abs(MIN) = 2^(W-1) as unsigned. Unsigned: raw value.
  - Clear partial remainder; count = W−1; go to CALC.
- IDLE, `int_exe`=0: hold all outputs.
- CALC, each cycle:
  - Shift {rem, quo} left 1.
  - If the trial subtraction rem − |divisor| ≥ 0 (W+1-bit compare), commit it and set the quotient LSB.
  - When count == 0, go to FIX; otherwise decrement count.
- FIX, one cycle:
  - Signed: negate quotient if the operand signs differ; negate remainder if the dividend was negative.
  - Register `lo`, `hi`, `div_zero`; go to IDLE.
- Divide by zero overrides the FIX result: `lo` = all ones, `hi` = original dividend (raw bits), `div_zero` = 1. Otherwise `div_zero` = 0.
- Signed MIN / −1: `lo` = MIN (wraps), `hi` = 0, `div_zero` = 0.
- `int_exe` in CALC or FIX: ignored. No queuing, operands not resampled.
- `dividend`, `divisor`, and `signed_op` may change freely after the start cycle.

## Timing

- Reset values: state IDLE; `intdiv_ready`=0, `lo`=0, `hi`=0, `div_zero`=0; internal registers 0.
- Reset during CALC/FIX aborts the divide. The next cycle is IDLE with all outputs 0, and the partial result is discarded.
- `reset` and `int_exe` asserted in the same cycle: reset wins; no divide starts.
- Cycle numbering, with `int_exe` sampled high in IDLE at the end of cycle T:
  - Cycles T+1 … T+W: CALC (W cycles).
  - Cycle T+W+1: FIX.
  - `intdiv_ready`=1 in cycles T+1 through T+W+1 (W+1 cycles). This covers the sequencer's one-cycle gap state before its wait state.
  - Cycle T+W+2: `intdiv_ready`=0; `lo`, `hi`, `div_zero` hold the new result. They are stable until the next completed divide or reset.
- Back-to-back operation: a new `int_exe` is accepted in cycle T+W+2 at the earliest, i.e. the first IDLE cycle.
- `lo`/`hi` keep the previous result throughout CALC/FIX and are updated only at the FIX edge.
- No combinational input-to-output paths.

## Test plan

1. Unsigned, W=32: 100 / 7, start at T.
   - `intdiv_ready` high exactly for cycles T+1..T+33.
   - At T+34: `lo`=14, `hi`=2, `div_zero`=0.
2. Signed: −7 / 2.
   - `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
   - Then signed 7 / −2: `lo`=0xFFFFFFFD, `hi`=1.
3. Divide by zero, unsigned 5 / 0.
   - `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1.
   - A following 9 / 3: `lo`=3, `hi`=0, `div_zero`=0.
4. Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
   - Unsigned same operands: `lo`=0, `hi`=0x80000000.
5. Start 100 / 7, then pulse `int_exe` with 50 / 5 at T+10 while changing operands.
   - Busy window unchanged.
   - Result stays `lo`=14, `hi`=2; the second start is ignored.
6. Start a divide, assert `reset` at T+5.
   - T+6: `intdiv_ready`=0, `lo`=`hi`=0, state IDLE.
   - A new 20 / 4 started afterward completes normally: `lo`=5, `hi`=0, W+1 busy cycles.
